// File: rtl/montmul_rk.sv
// rtl/montmul_rk.sv - radix-2^DIG digit-serial Montgomery multiplier
//
// Computes r = a*b*2^-WID mod m, consuming DIG bits of a per clock.
// Optional final conditional subtraction is compiled in when the macro
// MONTMUL_FINALSUB_EN is defined; otherwise r is the raw result in [0, 2m).
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (aborts an operation, no done)
//   start  in   request, sampled only while idle
//   a      in   [WID-1:0] multiplicand, a < m
//   b      in   [WID-1:0] multiplier, b < m
//   m      in   [WID-1:0] odd modulus
//   minv   in   [DIG-1:0] -m^-1 mod 2^DIG
//   busy   out  high from the accepting edge until the done cycle ends
//   done   out  one-cycle completion pulse
//   r      out  [WID:0] result, held from done until the next accepted start

module montmul_rk #(
    parameter int WID = 256,
    parameter int DIG = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    input  logic [WID-1:0] m,
    input  logic [DIG-1:0] minv,
    output logic           busy,
    output logic           done,
    output logic [WID:0]   r
);

    localparam int NIT = WID / DIG;
    localparam int CW  = $clog2(NIT + 1);
    // t + q*m stays below 2^DIG * 2m, so WID+DIG+1 bits never overflow.
    localparam int TW  = WID + DIG + 1;

    generate
        if ((WID % DIG) != 0) begin : g_param_err
            $error("montmul_rk: WID must be a multiple of DIG");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [WID-1:0]  asrg_q;
    logic [WID-1:0]  breg_q;
    logic [WID-1:0]  mreg_q;
    logic [DIG-1:0]  mireg_q;
    logic [WID:0]    acc_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [WID:0]    r_q;

    // One Montgomery digit step.
    logic [DIG-1:0]   ai;
    logic [TW-1:0]    t;
    logic [2*DIG-1:0] qprod;
    logic [DIG-1:0]   q;
    logic [TW-1:0]    u;
    logic [WID:0]     acc_d;
    logic             unused_bits;

    always_comb begin
        ai    = asrg_q[DIG-1:0];
        t     = TW'(acc_q) + TW'(ai) * TW'(breg_q);
        qprod = (2*DIG)'(t[DIG-1:0]) * (2*DIG)'(mireg_q);
        q     = qprod[DIG-1:0];
        u     = t + TW'(q) * TW'(mreg_q);
        // q is chosen so the low DIG bits of u are zero; the shift is exact.
        acc_d = u[TW-1:DIG];
    end

    assign unused_bits = ^{u[DIG-1:0], qprod[2*DIG-1:DIG]};

`ifdef MONTMUL_FINALSUB_EN
    logic [WID:0] fix_d;

    always_comb begin
        fix_d = acc_q;
        if (acc_q >= {1'b0, mreg_q}) begin
            fix_d = acc_q - {1'b0, mreg_q};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            asrg_q  <= '0;
            breg_q  <= '0;
            mreg_q  <= '0;
            mireg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        asrg_q  <= a;
                        breg_q  <= b;
                        mreg_q  <= m;
                        mireg_q <= minv;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q  <= acc_d;
                    asrg_q <= asrg_q >> DIG;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NIT - 1)) begin
`ifdef MONTMUL_FINALSUB_EN
                        state_q <= S_FIX;
`else
                        // r and done are registered on entry to DONE so the
                        // result is valid in the same cycle as the pulse.
                        r_q     <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef MONTMUL_FINALSUB_EN
                S_FIX: begin
                    acc_q   <= fix_d;
                    r_q     <= fix_d;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign r    = r_q;

endmodule

// File: tb/tb_montmul_rk.sv
// tb/tb_montmul_rk.sv - directed bench for montmul_rk (WID=8, DIG=2 and DIG=1, m=239)

module tb_montmul_rk;

`ifdef MONTMUL_FINALSUB_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT2 = 4 + 1 + EXTRA;
    localparam int LAT1 = 8 + 1 + EXTRA;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [1:0] minv2;
    logic [0:0] minv1;
    logic       start2;
    logic       start1;
    logic       busy2;
    logic       busy1;
    logic       done2;
    logic       done1;
    logic [8:0] r2;
    logic [8:0] r1;
    logic       cur_busy;
    logic       cur_done;
    logic [8:0] cur_r;

    int checks = 0;
    int errors = 0;

    assign start2   = start & ~sel;
    assign start1   = start & sel;
    assign cur_busy = sel ? busy1 : busy2;
    assign cur_done = sel ? done1 : done2;
    assign cur_r    = sel ? r1 : r2;

    montmul_rk #(.WID(8), .DIG(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a), .b(b), .m(m),
        .minv(minv2), .busy(busy2), .done(done2), .r(r2)
    );

    montmul_rk #(.WID(8), .DIG(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .m(m),
        .minv(minv1), .busy(busy1), .done(done1), .r(r1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the unique x in [0,239) with x*2^8 == a*b (mod 239).
    function automatic int mont_ref(input int av, input int bv);
        int p;
        p = (av * bv) % 239;
        for (int x = 0; x < 239; x++) begin
            if (((x * 256) % 239) == p) return x;
        end
        return -1;
    endfunction

    task automatic chk_res(input string tag, input logic [8:0] res, input int expv);
`ifdef MONTMUL_FINALSUB_EN
        check(tag, 32'(res), 32'(expv));
`else
        check(tag, 32'(res) % 239, 32'(expv));
        check({tag, "_range"}, 32'(res < 9'd478), 32'd1);
`endif
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 50; i++) begin
            if (!cur_busy) break;
            tick();
        end
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            if (cur_done) begin
                k = i;
                break;
            end
            tick();
        end
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output logic [8:0] res, output int lat, output int bcnt);
        wait_idle();
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (cur_busy) bcnt++;
            if (cur_done) begin
                lat = k;
                break;
            end
            tick();
        end
        res = cur_r;
    endtask

    logic [8:0] res;
    int lat;
    int bcnt;
    int k;
    int dcnt;
    int av;
    int bv;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        a     = '0;
        b     = '0;
        m     = 8'd239;
        minv2 = 2'd1;
        minv1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy2", 32'(busy2), 0);
        check("rst_done2", 32'(done2), 0);
        check("rst_r2", 32'(r2), 0);
        check("rst_busy1", 32'(busy1), 0);
        rst = 1'b0;
        tick();

        // Basic vectors, DIG=2.
        do_op(8'd5, 8'd7, res, lat, bcnt);
        chk_res("d2_5x7", res, 227);
        check("d2_lat", 32'(lat), 32'(LAT2));
        check("d2_busy_cycles", 32'(bcnt), 32'(LAT2));
        tick();
        check("d2_busy_after", 32'(busy2), 0);
        repeat (3) tick();
        check("d2_r_held", 32'(r2), 32'(res));

        do_op(8'd238, 8'd238, res, lat, bcnt);
        chk_res("d2_238x238", res, 225);
        do_op(8'd1, 8'd1, res, lat, bcnt);
        chk_res("d2_1x1", res, 225);
        do_op(8'd0, 8'd123, res, lat, bcnt);
        chk_res("d2_0x123", res, 0);

        // Start during an operation is ignored.
        wait_idle();
        a = 8'd5; b = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 8'd238; b = 8'd238; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(k);
        check("ign_done_seen", 32'(k > 0), 1);
        chk_res("ign_res", r2, 227);
        repeat (2) tick();
        check("ign_no_second", 32'(busy2), 0);

        // Start held high: next op accepted on the first idle edge.
        a = 8'd5; b = 8'd7; start = 1'b1;
        tick();
        tick();
        a = 8'd238; b = 8'd238;
        wait_done(k);
        check("b2b_first_seen", 32'(k > 0), 1);
        chk_res("b2b_first", r2, 227);
        tick();
        check("b2b_idle_gap", 32'(busy2), 0);
        tick();
        check("b2b_accepted", 32'(busy2), 1);
        start = 1'b0;
        wait_done(k);
        check("b2b_lat", 32'(k), 32'(LAT2));
        chk_res("b2b_second", r2, 225);

        // Reset in the third RUN cycle aborts without done.
        wait_idle();
        a = 8'd5; b = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy2), 0);
        check("abort_done", 32'(done2), 0);
        check("abort_r", 32'(r2), 0);
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done2) dcnt++;
            tick();
        end
        check("abort_no_done", 32'(dcnt), 0);
        do_op(8'd5, 8'd7, res, lat, bcnt);
        chk_res("abort_recover", res, 227);
        check("abort_recover_lat", 32'(lat), 32'(LAT2));

        // Random vectors against the reference, DIG=2.
        for (int i = 0; i < 20; i++) begin
            av = $urandom_range(0, 238);
            bv = $urandom_range(0, 238);
            do_op(8'(av), 8'(bv), res, lat, bcnt);
            chk_res($sformatf("d2_rand%0d", i), res, mont_ref(av, bv));
        end

        // Radix-2 instance.
        sel = 1'b1;
        tick();
        do_op(8'd5, 8'd7, res, lat, bcnt);
        chk_res("d1_5x7", res, 227);
        check("d1_lat", 32'(lat), 32'(LAT1));
        check("d1_busy_cycles", 32'(bcnt), 32'(LAT1));
        do_op(8'd238, 8'd238, res, lat, bcnt);
        chk_res("d1_238x238", res, 225);
        for (int i = 0; i < 20; i++) begin
            av = $urandom_range(0, 238);
            bv = $urandom_range(0, 238);
            do_op(8'(av), 8'(bv), res, lat, bcnt);
            chk_res($sformatf("d1_rand%0d", i), res, mont_ref(av, bv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
